// File: rtl/pwm_multi_ch.sv
// N-channel PWM: a shared sawtooth/triangle counter feeds NCH comparators; duties double-buffered to the period boundary.
// Latency: pwm_sig registered one cycle behind cnt, strobes combinational from cnt; no backpressure, duty_load always accepted.
module pwm_multi_ch #(
    parameter int WIDTH = 11,
    parameter int NCH   = 3,
    parameter int BLANK = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   center_mode,
    input  logic [NCH*WIDTH-1:0]   duty_flat,
    input  logic                   duty_load,
    output logic                   duty_pending,
    output logic [NCH-1:0]         pwm_sig,
    output logic                   pwm_synch,
    output logic                   ovr_i_blank_n
);

    localparam logic [WIDTH-1:0] L_MAX   = '1;
    localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] L_BLANK = WIDTH'(BLANK);

    logic [WIDTH-1:0]     r_cnt;
    logic                 r_dir_down;
    logic [NCH*WIDTH-1:0] r_pending;
    logic [NCH*WIDTH-1:0] r_active;
    logic                 r_duty_pending;
    logic [NCH-1:0]       r_pwm;

    logic                 w_boundary;
    logic [NCH*WIDTH-1:0] w_next_active;

    assign w_boundary    = en && (r_cnt == L_MAX);
    assign w_next_active = duty_load ? duty_flat : r_pending;

    // The mode only matters when leaving MAX, so center_mode is sampled there and
    // the direction bit carries it for the rest of the period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
        end else if (w_boundary) begin
            if (center_mode) begin
                r_cnt      <= L_MAX - L_ONE;
                r_dir_down <= 1'b1;
            end else begin
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
            end
        end else if (r_dir_down) begin
            r_cnt <= r_cnt - L_ONE;
            if (r_cnt == L_ONE) begin
                r_dir_down <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt + L_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= '0;
            r_active       <= '0;
            r_duty_pending <= 1'b0;
        end else begin
            if (duty_load) begin
                r_pending <= duty_flat;
            end
            if (!en || w_boundary) begin
                r_active       <= w_next_active;
                r_duty_pending <= 1'b0;
            end else if (duty_load) begin
                r_duty_pending <= 1'b1;
            end
        end
    end

    // cnt == MAX never compares below any duty, so the boundary swap cannot glitch.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_pwm[i] <= (r_cnt < r_active[i*WIDTH +: WIDTH]);
            end
        end
    end

    assign duty_pending  = r_duty_pending;
    assign pwm_sig       = r_pwm;
    assign pwm_synch     = !rst && w_boundary;
    assign ovr_i_blank_n = !rst && en && (r_cnt > L_BLANK);

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (WIDTH=11, NCH=3): per-period pulse statistics checked against a scoreboard.
module tb_pwm_multi_ch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        center_mode;
    logic [32:0] duty_flat;
    logic        duty_load;
    logic        duty_pending;
    logic [2:0]  pwm_sig;
    logic        pwm_synch;
    logic        ovr_i_blank_n;

    pwm_multi_ch #(.WIDTH(11), .NCH(3), .BLANK(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .center_mode   (center_mode),
        .duty_flat     (duty_flat),
        .duty_load     (duty_load),
        .duty_pending  (duty_pending),
        .pwm_sig       (pwm_sig),
        .pwm_synch     (pwm_synch),
        .ovr_i_blank_n (ovr_i_blank_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int hi[3];
    int synch_cnt, synch_idx, blank_lo, pend_cnt, first_hi0, last_hi0, pwm_first;
    int n;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input string t, input int v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic got(input int obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Samples n cycles; duty_load is dropped after the first edge.
    task automatic measure(input int len);
        for (int c = 0; c < 3; c++) hi[c] = 0;
        synch_cnt = 0; synch_idx = -1; blank_lo = 0; pend_cnt = 0;
        first_hi0 = -1; last_hi0 = -1; pwm_first = -1;
        for (int s = 0; s < len; s++) begin
            step();
            if (s == 0) begin
                duty_load = 1'b0;
                pwm_first = int'(pwm_sig);
            end
            for (int c = 0; c < 3; c++) if (pwm_sig[c] === 1'b1) hi[c]++;
            if (pwm_sig[0] === 1'b1) begin
                if (first_hi0 < 0) first_hi0 = s;
                last_hi0 = s;
            end
            if (pwm_synch === 1'b1) begin
                synch_cnt++;
                synch_idx = s;
            end
            if (ovr_i_blank_n !== 1'b1) blank_lo++;
            if (duty_pending === 1'b1) pend_cnt++;
        end
    endtask

    task automatic wait_synch(input int max_cycles, output int steps);
        steps = -1;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (pwm_synch === 1'b1) begin
                steps = i + 1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; center_mode = 1'b0; duty_flat = '0; duty_load = 1'b0;
        repeat (3) step();
        push("rst_pwm", 0); push("rst_pend", 0); push("rst_synch", 0); push("rst_blank", 0);
        got(int'(pwm_sig)); got(int'(duty_pending)); got(int'(pwm_synch)); got(int'(ovr_i_blank_n));

        // Edge mode, duties {7FF,000,100} loaded on the first running cycle
        rst = 1'b0; en = 1'b1;
        duty_flat = {11'h7FF, 11'h000, 11'h100};
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        push("load_pending", 1); got(int'(duty_pending));
        push("first_synch_wait", 2046);
        wait_synch(5000, n); got(n);
        push("edge_pwm_after_max", 0); push("edge_ch0_hi", 256); push("edge_ch1_hi", 0);
        push("edge_ch2_hi", 2047); push("edge_synch_cnt", 1); push("edge_synch_idx", 2047);
        push("edge_blank_lo", 256); push("edge_pend_cnt", 0);
        measure(2048);
        got(pwm_first); got(hi[0]); got(hi[1]); got(hi[2]); got(synch_cnt); got(synch_idx);
        got(blank_lo); got(pend_cnt);

        // Shadow load of ch0=0x400 at cnt=500
        repeat (501) step();
        duty_flat[10:0] = 11'h400;
        duty_load = 1'b1;
        push("shadow_ch0_hi_rest", 0); push("shadow_pend_cnt", 1547); push("shadow_synch_idx", 1546);
        measure(1547);
        got(hi[0]); got(pend_cnt); got(synch_idx);
        push("shadow_ch0_hi_next", 1024); push("shadow_pend_after", 0); push("shadow_ch2_hi", 2047);
        measure(2048);
        got(hi[0]); got(pend_cnt); got(hi[2]);

        // Load ch0=0x080 and switch to center mode on the synch cycle itself
        push("synch_at_window_end", 1); got(int'(pwm_synch));
        duty_flat[10:0] = 11'h080;
        duty_load = 1'b1;
        center_mode = 1'b1;
        push("ctr_ch0_hi", 255); push("ctr_ch1_hi", 0); push("ctr_ch2_hi", 4093);
        push("ctr_synch_cnt", 1); push("ctr_synch_idx", 4093); push("ctr_blank_lo", 511);
        push("ctr_pend_never", 0); push("ctr_ch0_first", 1920); push("ctr_ch0_last", 2174);
        push("ctr_pwm_after_max", 0);
        measure(4094);
        got(hi[0]); got(hi[1]); got(hi[2]); got(synch_cnt); got(synch_idx); got(blank_lo);
        got(pend_cnt); got(first_hi0); got(last_hi0); got(pwm_first);

        // Center mode, ch0=0x100 loaded mid-period on the down slope
        repeat (100) step();
        duty_flat[10:0] = 11'h100;
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        push("ctr_load_pending", 1); got(int'(duty_pending));
        push("ctr_synch_wait", 3993);
        wait_synch(10000, n); got(n);
        push("ctr2_ch0_hi", 511); push("ctr2_ch0_first", 1792); push("ctr2_ch0_last", 2302);
        push("ctr2_synch_idx", 4093); push("ctr2_pend_cnt", 0); push("ctr2_ch2_hi", 4093);
        measure(4094);
        got(hi[0]); got(first_hi0); got(last_hi0); got(synch_idx); got(pend_cnt); got(hi[2]);

        // Center to edge at the boundary: next cnt is 0, so blanking is active
        center_mode = 1'b0;
        step();
        push("ctr2edge_blank", 0); got(int'(ovr_i_blank_n));
        repeat (100) step();
        duty_flat[10:0] = 11'h200;
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        push("pre_idle_pending", 1); got(int'(duty_pending));
        repeat (199) step();
        push("run_blank_at_300", 1); got(int'(ovr_i_blank_n));
        en = 1'b0;
        step();
        push("idle_pwm", 0); push("idle_synch", 0); push("idle_blank", 0); push("idle_pend", 0);
        got(int'(pwm_sig)); got(int'(pwm_synch)); got(int'(ovr_i_blank_n)); got(int'(duty_pending));
        repeat (4) step();
        push("idle_pwm_hold", 0); got(int'(pwm_sig));
        en = 1'b1;
        push("resume_pwm_first", 5); push("resume_ch0_hi", 512); push("resume_ch2_hi", 2047);
        push("resume_synch_idx", 2046); push("resume_ch0_first", 0); push("resume_ch0_last", 511);
        measure(2048);
        got(pwm_first); got(hi[0]); got(hi[2]); got(synch_idx); got(first_hi0); got(last_hi0);

        // Mid-period reset at cnt=700 with a load pending
        repeat (700) step();
        duty_flat[10:0] = 11'h300;
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        push("prereset_pending", 1); push("prereset_pwm", 4);
        got(int'(duty_pending)); got(int'(pwm_sig));
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            push("inrst_pwm", 0); push("inrst_pend", 0); push("inrst_synch", 0); push("inrst_blank", 0);
            got(int'(pwm_sig)); got(int'(duty_pending)); got(int'(pwm_synch)); got(int'(ovr_i_blank_n));
        end
        rst = 1'b0;
        push("postrst_synch_wait", 2047);
        wait_synch(5000, n); got(n);
        push("postrst_ch0_hi", 0); push("postrst_ch2_hi", 0); push("postrst_synch_cnt", 1);
        measure(2048);
        got(hi[0]); got(hi[2]); got(synch_cnt);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
